// File: rtl/rw_byte_register_pkg.sv
// Shared definitions for the command-decoder argument registers.
// The strobe encodings are also used by the decoder when it drives the registers.
package rw_byte_register_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned ARG_WIDTH = 8;
    localparam int unsigned NUM_ARGS  = 3;

    // Bit offset of argument byte n (1..NUM_ARGS) inside the decoder's packed buffer.
    function automatic int unsigned arg_lsb(input int unsigned arg_index);
        return (arg_index - 1) * ARG_WIDTH;
    endfunction

endpackage

// File: rtl/rw_byte_register.sv
// Single-word storage register: captures d on a write strobe, otherwise holds.
// q comes straight from the flops, so nothing reaches it between edges.
module rw_byte_register
    import rw_byte_register_pkg::*;
#(
    parameter int unsigned          WIDTH       = ARG_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rw,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: state is updated with <= so every reader sees the pre-edge value;
    // testing rst first gives reset priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (rw == RW_WRITE) begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_rw_byte_register.sv
// Self-checking bench for rw_byte_register: directed scenarios plus random traffic,
// two instances (default reset value and 8'h5A) compared against a reference model.
module tb_rw_byte_register;
    import rw_byte_register_pkg::*;

    localparam logic [7:0] RV_A = 8'h00;
    localparam logic [7:0] RV_B = 8'h5A;

    logic       clk;
    logic       rst;
    logic       rw;
    logic [7:0] d;
    logic [7:0] q_a;
    logic [7:0] q_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: the word each instance should currently present.
    logic [7:0] exp_a;
    logic [7:0] exp_b;

    rw_byte_register #(.WIDTH(8), .RESET_VALUE(RV_A)) dut_a (
        .clk(clk), .rst(rst), .rw(rw), .d(d), .q(q_a)
    );

    rw_byte_register #(.WIDTH(8), .RESET_VALUE(RV_B)) dut_b (
        .clk(clk), .rst(rst), .rw(rw), .d(d), .q(q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name);
        checks++;
        if (q_a !== exp_a) begin
            failures++;
            $display("FAIL %s (rv=00): q=%h expected=%h", name, q_a, exp_a);
        end
        checks++;
        if (q_b !== exp_b) begin
            failures++;
            $display("FAIL %s (rv=5A): q=%h expected=%h", name, q_b, exp_b);
        end
    endtask

    // Drive inputs, take one rising edge, update the model from the register's
    // rules, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic w, input logic [7:0] data, input string name);
        rst = r;
        rw  = w;
        d   = data;
        @(posedge clk);
        if (r) begin
            exp_a = RV_A;
            exp_b = RV_B;
        end else if (w) begin
            exp_a = data;
            exp_b = data;
        end
        #1;
        compare(name);
    endtask

    task automatic test_reset();
        step(1'b1, RW_WRITE, 8'hA5, "reset_beats_write");
    endtask

    task automatic test_write();
        rst = 1'b0; rw = RW_READ; d = 8'h3C;
        #1;
        compare("before_write");
        step(1'b0, RW_WRITE, 8'h3C, "write_3c");
    endtask

    task automatic test_hold();
        logic [7:0] pattern [4];
        pattern = '{8'hFF, 8'h00, 8'h55, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, RW_READ, pattern[i], "hold");
        end
        checks++;
        if (q_a !== 8'h3C) begin
            failures++;
            $display("FAIL hold_value: q=%h expected=3c", q_a);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, RW_WRITE, 8'h01, "b2b_01");
        step(1'b0, RW_WRITE, 8'h02, "b2b_02");
        step(1'b0, RW_WRITE, 8'h80, "b2b_80");
    endtask

    task automatic test_glitch();
        // Pulse the strobe and change d between edges; no edge sees them.
        rst = 1'b0; rw = RW_WRITE; d = 8'h99;
        #2;
        compare("glitch_no_comb_path");
        rw = RW_READ;
        step(1'b0, RW_READ, 8'h99, "glitch_next_edge");
    endtask

    task automatic test_reset_mid_operation();
        step(1'b1, RW_WRITE, 8'h7E, "reset_mid_op");
        step(1'b0, RW_WRITE, 8'h7E, "write_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic       w;
            logic [7:0] data;
            r    = ($urandom_range(0, 15) == 0);
            w    = $urandom_range(0, 1) != 0;
            data = 8'($urandom);
            step(r, w, data, "random");
        end
    endtask

    initial begin
        rst = 1'b0;
        rw  = RW_READ;
        d   = '0;
        exp_a = 'x;
        exp_b = 'x;
        @(negedge clk);
        test_reset();
        test_write();
        test_hold();
        test_back_to_back();
        test_glitch();
        test_reset_mid_operation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
